// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side responder.
package core_pkg;

    // Grant FSM states: IDLE waits for a request, WAIT counts down the grant delay.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_resp_state_e;

    // One response slot travelling through the latency pipeline.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    localparam int MEM_RESP_MAX_LATENCY     = 8;
    localparam int MEM_RESP_MAX_GRANT_DELAY = 15;

    // Access is illegal when misaligned or when the offset from the base falls
    // outside the array. The offset wraps in 32 bits, so an address below the
    // base lands far above the span and is rejected by the same compare.
    function automatic logic mem_resp_addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span_bytes
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ({1'b0, off} >= span_bytes);
    endfunction

endpackage

// File: rtl/core_mem_resp_pipe.sv
// Fixed-depth response shift register; the last stage drives the responder outputs.
module core_mem_resp_pipe
    import core_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      arst_i,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t stage_q [LATENCY];
    mem_resp_t stage_d [LATENCY];

    // Shift every slot one stage toward the output, new response enters stage 0.
    always_comb begin
        stage_d[0] = resp_i;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset discards every response still in flight.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the req/grant/valid protocol: word array with
// configurable grant delay and fixed in-order response latency.
module core_mem_responder
    import core_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1,
    parameter int          GRANT_DELAY = 0
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           req_i,
    output logic                           grnt_o,
    input  logic [31:0]                    addr_i,
    input  logic                           wen_i,
    input  logic [31:0]                    wdata_i,
    output logic                           valid_o,
    output logic [31:0]                    rdata_o,
    output logic                           err_o,
    input  logic                           init_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                    init_data_i
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT   = (GRANT_DELAY > 0) ? 4'(GRANT_DELAY - 1) : 4'd0;

    // Parameter legality, rejected at elaboration.
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("core_mem_responder: DEPTH_WORDS must be a power of two");
    end
    if (({1'b0, BASE_ADDR} & (SPAN_BYTES - 33'd1)) != 33'd0) begin : g_bad_base
        $error("core_mem_responder: BASE_ADDR must be aligned to the array size");
    end
    if (LATENCY < 1 || LATENCY > MEM_RESP_MAX_LATENCY) begin : g_bad_latency
        $error("core_mem_responder: LATENCY out of range 1..8");
    end
    if (GRANT_DELAY < 0 || GRANT_DELAY > MEM_RESP_MAX_GRANT_DELAY) begin : g_bad_gdelay
        $error("core_mem_responder: GRANT_DELAY out of range 0..15");
    end

    mem_resp_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            grnt_s;
    logic            hs_s;
    logic            addr_err_s;
    logic [AW-1:0]   idx_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [31:0]     mem_wdata_s;
    logic [31:0]     mem_q [DEPTH_WORDS];
    mem_resp_t       resp_in_s;
    mem_resp_t       resp_out_s;

    // Grant FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant FSM next state: preload freezes everything, a dropped request aborts the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_we_i || GRANT_DELAY == 0) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end else if (req_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
            end
            WAIT: begin
                if (init_we_i) begin
                    state_d = WAIT;
                    cnt_d   = cnt_q;
                end else if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Grant FSM output: combinational grant, suppressed during reset and preload.
    always_comb begin
        grnt_s = 1'b0;
        if (arst_i || init_we_i) begin
            grnt_s = 1'b0;
        end else if (GRANT_DELAY == 0) begin
            grnt_s = req_i && (state_q == IDLE);
        end else begin
            grnt_s = req_i && (state_q == WAIT) && (cnt_q == 4'd0);
        end
    end

    assign grnt_o = grnt_s;
    assign hs_s   = req_i && grnt_s;

    // Address decode for the request currently presented.
    always_comb begin
        addr_err_s = mem_resp_addr_err(addr_i, BASE_ADDR, SPAN_BYTES);
        idx_s      = AW'((addr_i - BASE_ADDR) >> 2);
    end

    // Array write port: preload and a legal write handshake never coincide.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = init_addr_i;
        mem_wdata_s = init_data_i;
        if (init_we_i) begin
            mem_we_s = 1'b1;
        end else if (hs_s && wen_i && !addr_err_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = idx_s;
            mem_wdata_s = wdata_i;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Word array storage; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Response captured at the handshake edge: read data reflects the array before this edge's write.
    always_comb begin
        resp_in_s = '0;
        if (hs_s) begin
            resp_in_s.valid = 1'b1;
            resp_in_s.err   = addr_err_s;
            resp_in_s.rdata = (addr_err_s || wen_i) ? 32'd0 : mem_q[idx_s];
        end else begin
            resp_in_s = '0;
        end
    end

    core_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .resp_i (resp_in_s),
        .resp_o (resp_out_s)
    );

    assign valid_o = resp_out_s.valid;
    assign err_o   = resp_out_s.err;
    assign rdata_o = resp_out_s.rdata;

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench: three responder instances with different grant delay,
// latency and base address; stimulus pushes expected responses, a monitor
// pops and compares them when valid_o is seen.
module tb_core_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        arst      [3];
    logic        req       [3];
    logic [31:0] addr      [3];
    logic        wen       [3];
    logic [31:0] wdata     [3];
    logic        init_we   [3];
    logic [9:0]  init_addr [3];
    logic [31:0] init_data [3];
    logic        grnt      [3];
    logic        valid     [3];
    logic        err       [3];
    logic [31:0] rdata     [3];

    typedef struct {
        int          dut;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    core_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1), .GRANT_DELAY(0)) u_dut0 (
        .clk_i(clk), .arst_i(arst[0]), .req_i(req[0]), .grnt_o(grnt[0]), .addr_i(addr[0]),
        .wen_i(wen[0]), .wdata_i(wdata[0]), .valid_o(valid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .init_we_i(init_we[0]), .init_addr_i(init_addr[0]), .init_data_i(init_data[0]));

    core_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(3), .GRANT_DELAY(0)) u_dut1 (
        .clk_i(clk), .arst_i(arst[1]), .req_i(req[1]), .grnt_o(grnt[1]), .addr_i(addr[1]),
        .wen_i(wen[1]), .wdata_i(wdata[1]), .valid_o(valid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .init_we_i(init_we[1]), .init_addr_i(init_addr[1]), .init_data_i(init_data[1]));

    core_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_4000), .LATENCY(2), .GRANT_DELAY(3)) u_dut2 (
        .clk_i(clk), .arst_i(arst[2]), .req_i(req[2]), .grnt_o(grnt[2]), .addr_i(addr[2]),
        .wen_i(wen[2]), .wdata_i(wdata[2]), .valid_o(valid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
        .init_we_i(init_we[2]), .init_addr_i(init_addr[2]), .init_data_i(init_data[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Monitor: pop the oldest expectation of each instance when it presents a response.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].dut == d) begin
                    idx = i;
                    break;
                end
            end
            if (valid[d] === 1'b1) begin
                if (idx < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid dut%0d: got valid=1 expected no response (cycle %0d)", d, cyc);
                end else begin
                    check("resp_cycle", d, cyc, exp_q[idx].cyc);
                    check("resp_err", d, {31'd0, err[d]}, {31'd0, exp_q[idx].err});
                    check("resp_rdata", d, rdata[d], exp_q[idx].rdata);
                    exp_q.delete(idx);
                end
            end else begin
                check("idle_err", d, {31'd0, err[d]}, 32'd0);
                check("idle_rdata", d, rdata[d], 32'd0);
                if (idx >= 0 && exp_q[idx].cyc <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_resp dut%0d: got valid=0 expected response due in cycle %0d (cycle %0d)",
                             d, exp_q[idx].cyc, cyc);
                    exp_q.delete(idx);
                end
            end
        end
    end

    task automatic preload(input int d, input logic [9:0] ia, input logic [31:0] id);
        init_we[d]   = 1'b1;
        init_addr[d] = ia;
        init_data[d] = id;
        @(posedge clk);
        #1;
        init_we[d] = 1'b0;
    endtask

    // Issue one request, wait (bounded) for its grant, push the expected response.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, output int waited);
        exp_t e;
        logic granted;
        req[d]   = 1'b1;
        wen[d]   = w;
        addr[d]  = a;
        wdata[d] = wd;
        waited   = 0;
        granted  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grnt[d] === 1'b1) begin
                granted = 1'b1;
                break;
            end
            waited++;
        end
        if (!granted) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout dut%0d: got no grant expected grant for addr %h", d, a);
            req[d] = 1'b0;
            wen[d] = 1'b0;
        end else begin
            e.dut   = d;
            e.cyc   = cyc + lat_of(d);
            e.err   = e_err;
            e.rdata = e_rd;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            req[d] = 1'b0;
            wen[d] = 1'b0;
        end
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        for (int d = 0; d < 3; d++) begin
            arst[d] = 1'b1; req[d] = 1'b0; addr[d] = 32'd0; wen[d] = 1'b0; wdata[d] = 32'd0;
            init_we[d] = 1'b0; init_addr[d] = 10'd0; init_data[d] = 32'd0;
        end
        req[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_grnt", d, {31'd0, grnt[d]}, 32'd0);
            check("reset_valid", d, {31'd0, valid[d]}, 32'd0);
        end
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        for (int d = 0; d < 3; d++) arst[d] = 1'b0;

        // Preloaded read, same-cycle grant, response next cycle.
        preload(0, 10'd3, 32'hDEAD_BEEF);
        txn(0, 1'b0, 32'h0000_000C, 32'd0, 1'b0, 32'hDEAD_BEEF, w);
        check("grant_same_cycle", 0, w, 32'd0);

        // Write then read of the same word on consecutive handshakes.
        txn(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'd0, w);
        txn(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'h1234_5678, w);

        // Misaligned and beyond-end accesses.
        txn(0, 1'b0, 32'h0000_0002, 32'd0, 1'b1, 32'd0, w);
        txn(0, 1'b0, 32'h0000_1000, 32'd0, 1'b1, 32'd0, w);
        preload(0, 10'd0, 32'h0000_1111);
        txn(0, 1'b1, 32'h0000_0002, 32'hBAD0_BAD0, 1'b1, 32'd0, w);
        txn(0, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'h0000_1111, w);

        // Last legal word.
        txn(0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'd0, w);
        txn(0, 1'b0, 32'h0000_0FFC, 32'd0, 1'b0, 32'hCAFE_F00D, w);

        // Preload and request together: preload wins, request stays pending.
        init_we[0] = 1'b1; init_addr[0] = 10'd5; init_data[0] = 32'h5555_AAAA;
        req[0] = 1'b1; addr[0] = 32'h0000_0014; wen[0] = 1'b0;
        @(negedge clk);
        check("preload_blocks_grant", 0, {31'd0, grnt[0]}, 32'd0);
        @(posedge clk);
        #1;
        init_we[0] = 1'b0;
        txn(0, 1'b0, 32'h0000_0014, 32'd0, 1'b0, 32'h5555_AAAA, w);
        check("pending_after_preload", 0, w, 32'd0);

        // Back-to-back streaming with latency 3.
        preload(1, 10'd0, 32'hA000_0000);
        preload(1, 10'd1, 32'hA000_0001);
        preload(1, 10'd2, 32'hA000_0002);
        txn(1, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'hA000_0000, w);
        check("stream_grant0", 1, w, 32'd0);
        txn(1, 1'b0, 32'h0000_0004, 32'd0, 1'b0, 32'hA000_0001, w);
        check("stream_grant1", 1, w, 32'd0);
        txn(1, 1'b0, 32'h0000_0008, 32'd0, 1'b0, 32'hA000_0002, w);
        check("stream_grant2", 1, w, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Reset with two responses in flight: they must never appear.
        preload(1, 10'd4, 32'hB000_0004);
        txn(1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hB000_0004, w);
        txn(1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hB000_0004, w);
        arst[1] = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].dut == 1) exp_q.delete(i);
        end
        #1;
        check("midflight_valid", 1, {31'd0, valid[1]}, 32'd0);
        check("midflight_rdata", 1, rdata[1], 32'd0);
        @(posedge clk);
        #1;
        arst[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        txn(1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hB000_0004, w);
        check("after_reset_grant", 1, w, 32'd0);

        // Grant delay 3 with request held.
        preload(2, 10'd0, 32'hC000_0000);
        txn(2, 1'b0, 32'h0000_4000, 32'd0, 1'b0, 32'hC000_0000, w);
        check("gdelay_first", 2, w, 32'd3);
        txn(2, 1'b0, 32'h0000_4000, 32'd0, 1'b0, 32'hC000_0000, w);
        check("gdelay_reenter", 2, w, 32'd3);

        // Request dropped during the wait: no grant, no response, FSM back to IDLE.
        req[2] = 1'b1; addr[2] = 32'h0000_4000; wen[2] = 1'b0;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(negedge clk);
        check("drop_no_grant", 2, {31'd0, grnt[2]}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        txn(2, 1'b0, 32'h0000_4000, 32'd0, 1'b0, 32'hC000_0000, w);
        check("drop_back_idle", 2, w, 32'd3);

        // Range check relative to a nonzero base.
        txn(2, 1'b0, 32'h0000_3FFC, 32'd0, 1'b1, 32'd0, w);
        txn(2, 1'b0, 32'h0000_5000, 32'd0, 1'b1, 32'd0, w);
        txn(2, 1'b1, 32'h0000_4FFC, 32'h7777_8888, 1'b0, 32'd0, w);
        txn(2, 1'b0, 32'h0000_4FFC, 32'd0, 1'b0, 32'h7777_8888, w);

        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("leftover_expected", 0, exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
